// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare branch direction predictor:
// FSM states, counter constants and the PC/history index hash.
package gshare_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } gshare_state_t;

    // Weakly-taken: MSB set, all lower bits clear.
    function automatic logic [31:0] ctr_init(input int ctr_w);
        return 32'(1) << (ctr_w - 1);
    endfunction

    function automatic logic [31:0] ctr_max(input int ctr_w);
        return (32'(1) << ctr_w) - 32'd1;
    endfunction

    // Caller truncates to the index width; history is zero-extended so only low bits mix.
    function automatic logic [63:0] gshare_hash(input logic [63:0] pc,
                                                input logic [63:0] hist,
                                                input int          pc_shift);
        return (pc >> pc_shift) ^ hist;
    endfunction

endpackage

// File: rtl/gshare_sat_ctr.sv
// Combinational saturating up/down counter step: taken increments, not-taken decrements.
module gshare_sat_ctr
    import gshare_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic             taken,
    input  logic [CTR_W-1:0] cur,
    output logic [CTR_W-1:0] next
);

    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max(CTR_W));

    always_comb begin
        next = cur;
        if (taken && (cur != CTR_MAX)) begin
            next = cur + CTR_W'(1);
        end else if (!taken && (cur != '0)) begin
            next = cur - CTR_W'(1);
        end
    end

endmodule

// File: rtl/gshare_predictor_param.sv
// Parametrised gshare predictor with reset init sweep, speculative GHR and mispredict repair.
// Optional GSHARE_STATS_EN adds saturating prediction / mispredict counters.
module gshare_predictor_param
    import gshare_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int IDX_W    = 12,
    parameter int HIST_W   = 12,
    parameter int CTR_W    = 2,
    parameter int PC_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pred_valid_i,
    input  logic [PC_W-1:0]   pred_pc_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    output logic [HIST_W-1:0] pred_hist_o,
    input  logic              upd_valid_i,
    input  logic [PC_W-1:0]   upd_pc_i,
    input  logic [HIST_W-1:0] upd_hist_i,
    input  logic              upd_taken_i,
    input  logic              upd_mispred_i,
    output logic              busy_o
`ifdef GSHARE_STATS_EN
    ,
    output logic [31:0]       stat_pred_o,
    output logic [31:0]       stat_mispred_o
`endif
);

    localparam int               DEPTH    = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

    gshare_state_t     state_reg, state_next;
    logic [IDX_W-1:0]  sweep_ptr_reg, sweep_ptr_next;
    logic [HIST_W-1:0] ghr_reg, ghr_next;
    logic              pred_valid_reg, pred_taken_reg;
    logic [HIST_W-1:0] pred_hist_reg;
    logic [CTR_W-1:0]  table_mem [DEPTH];

    logic              ready;
    logic              do_pred, do_upd, do_repair;
    logic [IDX_W-1:0]  pred_idx, upd_idx;
    logic              pred_bit;
    logic [CTR_W-1:0]  upd_cur, upd_new;
    logic [HIST_W-1:0] ghr_spec, ghr_fix;

    assign ready     = (state_reg == READY);
    assign do_pred   = ready && pred_valid_i;
    assign do_upd    = ready && upd_valid_i;
    assign do_repair = do_upd && upd_mispred_i;

    assign pred_idx = IDX_W'(gshare_hash(64'(pred_pc_i), 64'(ghr_reg), PC_SHIFT));
    assign upd_idx  = IDX_W'(gshare_hash(64'(upd_pc_i), 64'(upd_hist_i), PC_SHIFT));
    assign pred_bit = table_mem[pred_idx][CTR_W-1];
    assign upd_cur  = table_mem[upd_idx];

    gshare_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
        .taken (upd_taken_i),
        .cur   (upd_cur),
        .next  (upd_new)
    );

    // A one-bit history has nothing to shift; it simply takes the new outcome.
    generate
        if (HIST_W == 1) begin : g_hist_one
            assign ghr_spec = pred_bit;
            assign ghr_fix  = upd_taken_i;
        end else begin : g_hist_shift
            assign ghr_spec = {ghr_reg[HIST_W-2:0], pred_bit};
            assign ghr_fix  = {upd_hist_i[HIST_W-2:0], upd_taken_i};
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        sweep_ptr_next = sweep_ptr_reg;
        case (state_reg)
            INIT: begin
                sweep_ptr_next = sweep_ptr_reg + IDX_W'(1);
                if (sweep_ptr_reg == '1) begin
                    state_next = READY;
                end
            end
            READY:   state_next = READY;
            default: state_next = INIT;
        endcase
    end

    // Repair wins over the same-cycle speculative shift.
    always_comb begin
        ghr_next = ghr_reg;
        if (do_pred)   ghr_next = ghr_spec;
        if (do_repair) ghr_next = ghr_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= INIT;
            sweep_ptr_reg  <= '0;
            ghr_reg        <= '0;
            pred_valid_reg <= 1'b0;
            pred_taken_reg <= 1'b0;
            pred_hist_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            sweep_ptr_reg  <= sweep_ptr_next;
            ghr_reg        <= ghr_next;
            pred_valid_reg <= do_pred;
            if (do_pred) begin
                pred_taken_reg <= pred_bit;
                pred_hist_reg  <= ghr_reg;
            end
        end
    end

    // Single write port: sweep owns it during INIT, retire updates afterwards.
    always_ff @(posedge clk) begin
        if (state_reg == INIT) begin
            table_mem[sweep_ptr_reg] <= CTR_INIT;
        end else if (do_upd) begin
            table_mem[upd_idx] <= upd_new;
        end
    end

    assign pred_valid_o = pred_valid_reg;
    assign pred_taken_o = pred_taken_reg;
    assign pred_hist_o  = pred_hist_reg;
    assign busy_o       = !ready;

`ifdef GSHARE_STATS_EN
    logic [31:0] stat_pred_reg, stat_mispred_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pred_reg    <= '0;
            stat_mispred_reg <= '0;
        end else begin
            if (do_pred && (stat_pred_reg != '1)) begin
                stat_pred_reg <= stat_pred_reg + 32'd1;
            end
            if (do_repair && (stat_mispred_reg != '1)) begin
                stat_mispred_reg <= stat_mispred_reg + 32'd1;
            end
        end
    end

    assign stat_pred_o    = stat_pred_reg;
    assign stat_mispred_o = stat_mispred_reg;
`endif

endmodule

// File: tb/tb_gshare_predictor_param.sv
// Self-checking bench for gshare_predictor_param (IDX_W=HIST_W=4); vector table plus scoreboard.
module tb_gshare_predictor_param;

    localparam int PC_W     = 32;
    localparam int IDX_W    = 4;
    localparam int HIST_W   = 4;
    localparam int CTR_W    = 2;
    localparam int PC_SHIFT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              pred_valid_i;
    logic [PC_W-1:0]   pred_pc_i;
    logic              pred_valid_o;
    logic              pred_taken_o;
    logic [HIST_W-1:0] pred_hist_o;
    logic              upd_valid_i;
    logic [PC_W-1:0]   upd_pc_i;
    logic [HIST_W-1:0] upd_hist_i;
    logic              upd_taken_i;
    logic              upd_mispred_i;
    logic              busy_o;
`ifdef GSHARE_STATS_EN
    logic [31:0]       stat_pred_o;
    logic [31:0]       stat_mispred_o;
`endif

    always #5 clk = ~clk;

    gshare_predictor_param #(
        .PC_W(PC_W), .IDX_W(IDX_W), .HIST_W(HIST_W), .CTR_W(CTR_W), .PC_SHIFT(PC_SHIFT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pred_valid_i  (pred_valid_i),
        .pred_pc_i     (pred_pc_i),
        .pred_valid_o  (pred_valid_o),
        .pred_taken_o  (pred_taken_o),
        .pred_hist_o   (pred_hist_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_hist_i    (upd_hist_i),
        .upd_taken_i   (upd_taken_i),
        .upd_mispred_i (upd_mispred_i),
        .busy_o        (busy_o)
`ifdef GSHARE_STATS_EN
        ,
        .stat_pred_o   (stat_pred_o),
        .stat_mispred_o(stat_mispred_o)
`endif
    );

    typedef struct {
        logic       taken;
        logic [3:0] hist;
    } exp_t;

    typedef struct {
        string      name;
        logic       pv;
        logic [31:0] pc;
        logic       uv;
        logic [31:0] upc;
        logic [3:0] uhist;
        logic       ut;
        logic       um;
        logic       et;
        logic [3:0] eh;
    } vec_t;

    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];
    vec_t vecs[$];

    // Reference model state, written purely from the behavioural description.
    int         ctr_m[16];
    logic [3:0] ghr_m;
    logic       last_t;
    logic [3:0] last_h;
    int         n_pred;
    int         n_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input string n, input logic pv, input logic [31:0] pc,
                                input logic uv, input logic [31:0] upc, input logic [3:0] uh,
                                input logic ut, input logic um, input logic et, input logic [3:0] eh);
        vec_t v;
        v.name = n; v.pv = pv; v.pc = pc; v.uv = uv; v.upc = upc;
        v.uhist = uh; v.ut = ut; v.um = um; v.et = et; v.eh = eh;
        return v;
    endfunction

    task automatic idle_inputs();
        pred_valid_i  = 1'b0;
        pred_pc_i     = '0;
        upd_valid_i   = 1'b0;
        upd_pc_i      = '0;
        upd_hist_i    = '0;
        upd_taken_i   = 1'b0;
        upd_mispred_i = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ctr_m[i] = 2;
        ghr_m  = '0;
        last_t = 1'b0;
        last_h = '0;
        n_pred = 0;
        n_mis  = 0;
    endtask

    // One clock of stimulus; expectation comes from the vector or, if use_model, from the model.
    task automatic run_cycle(input vec_t v, input bit use_model);
        logic [3:0] pidx, uidx;
        logic       mt;
        exp_t       e;
        pred_valid_i  = v.pv;
        pred_pc_i     = v.pc;
        upd_valid_i   = v.uv;
        upd_pc_i      = v.upc;
        upd_hist_i    = v.uhist;
        upd_taken_i   = v.ut;
        upd_mispred_i = v.um;
        pidx = 4'((v.pc >> 2) ^ 32'(ghr_m));
        mt   = (ctr_m[pidx] >= 2);
        if (v.pv) begin
            e.taken = use_model ? mt : v.et;
            e.hist  = use_model ? ghr_m : v.eh;
            sb.push_back(e);
            n_pred++;
        end
        if (v.uv) begin
            uidx = 4'((v.upc >> 2) ^ 32'(v.uhist));
            if (v.ut) begin
                if (ctr_m[uidx] < 3) ctr_m[uidx]++;
            end else if (ctr_m[uidx] > 0) begin
                ctr_m[uidx]--;
            end
        end
        if (v.pv) ghr_m = {ghr_m[2:0], mt};
        if (v.uv && v.um) begin
            ghr_m = {v.uhist[2:0], v.ut};
            n_mis++;
        end
        @(posedge clk);
        #1;
        if (v.pv) begin
            e = sb.pop_front();
            check({v.name, " valid"}, 32'(pred_valid_o), 32'd1);
            check({v.name, " taken"}, 32'(pred_taken_o), 32'(e.taken));
            check({v.name, " hist"},  32'(pred_hist_o),  32'(e.hist));
            last_t = e.taken;
            last_h = e.hist;
        end else begin
            check({v.name, " valid"},     32'(pred_valid_o), 32'd0);
            check({v.name, " hold taken"}, 32'(pred_taken_o), 32'(last_t));
            check({v.name, " hold hist"},  32'(pred_hist_o),  32'(last_h));
        end
        $display("cycle %s pv=%0b pc=%0h uv=%0b um=%0b -> valid=%0b taken=%0b hist=%0h",
                 v.name, v.pv, v.pc, v.uv, v.um, pred_valid_o, pred_taken_o, pred_hist_o);
        idle_inputs();
    endtask

    // Called between edges: releases reset with requests asserted and counts busy cycles.
    task automatic release_and_sweep(input string tag);
        int cnt = 0;
        pred_valid_i  = 1'b1;
        pred_pc_i     = 32'h40;
        upd_valid_i   = 1'b1;
        upd_pc_i      = 32'h100;
        upd_hist_i    = 4'hf;
        upd_taken_i   = 1'b1;
        upd_mispred_i = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 64 && busy_o; i++) begin
            check({tag, " init valid"}, 32'(pred_valid_o), 32'd0);
            cnt++;
            @(negedge clk);
        end
        idle_inputs();
        check({tag, " busy cycles"}, 32'(cnt), 32'd16);
        check({tag, " post-sweep hist"}, 32'(pred_hist_o), 32'd0);
`ifdef GSHARE_STATS_EN
        check({tag, " stat_pred init"},    stat_pred_o,    32'd0);
        check({tag, " stat_mispred init"}, stat_mispred_o, 32'd0);
`endif
        $display("sweep %s: busy for %0d cycles", tag, cnt);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},  32'(busy_o),       32'd1);
        check({tag, " valid"}, 32'(pred_valid_o), 32'd0);
        check({tag, " taken"}, 32'(pred_taken_o), 32'd0);
        check({tag, " hist"},  32'(pred_hist_o),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_and_sweep("rst1");

        vecs.push_back(mk("pred40",  1, 32'h40, 0, 32'h0,   4'h0, 0, 0, 1, 4'h0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("upd_t", 0, 32'h0, 1, 32'h100, 4'h0, 1, 0, 0, 4'h0));
        vecs.push_back(mk("upd_nt1", 0, 32'h0,  1, 32'h100, 4'h0, 0, 0, 0, 4'h0));
        vecs.push_back(mk("pred04",  1, 32'h04, 0, 32'h0,   4'h0, 0, 0, 1, 4'h1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("upd_nt", 0, 32'h0, 1, 32'h100, 4'h0, 0, 0, 0, 4'h0));
        vecs.push_back(mk("upd_t1",  0, 32'h0,  1, 32'h100, 4'h0, 1, 0, 0, 4'h0));
        vecs.push_back(mk("pred0c",  1, 32'h0c, 0, 32'h0,   4'h0, 0, 0, 0, 4'h3));
        vecs.push_back(mk("ghr_clr", 0, 32'h0,  1, 32'h3c,  4'h0, 0, 1, 0, 4'h0));
        vecs.push_back(mk("b2b0",    1, 32'h10, 0, 32'h0,   4'h0, 0, 0, 1, 4'h0));
        vecs.push_back(mk("b2b1",    1, 32'h14, 0, 32'h0,   4'h0, 0, 0, 1, 4'h1));
        vecs.push_back(mk("b2b2",    1, 32'h18, 0, 32'h0,   4'h0, 0, 0, 1, 4'h3));
        vecs.push_back(mk("mispred", 1, 32'h20, 1, 32'h00,  4'h1, 0, 1, 0, 4'h7));
        vecs.push_back(mk("ghr_fix", 1, 32'h00, 0, 32'h0,   4'h0, 0, 0, 1, 4'h2));
        vecs.push_back(mk("same_rd", 1, 32'h10, 1, 32'h04,  4'h0, 1, 0, 0, 4'h5));
        vecs.push_back(mk("same_wr", 1, 32'h2c, 0, 32'h0,   4'h0, 0, 0, 1, 4'ha));
        foreach (vecs[i]) run_cycle(vecs[i], 1'b0);

        for (int i = 0; i < 60; i++) begin
            v = mk("rand", 1'($urandom), $urandom, 1'($urandom), $urandom,
                   4'($urandom), 1'($urandom), 1'b0, 1'b0, 4'h0);
            v.um = v.uv & 1'($urandom);
            run_cycle(v, 1'b1);
        end
`ifdef GSHARE_STATS_EN
        check("stat_pred run",    stat_pred_o,    32'(n_pred));
        check("stat_mispred run", stat_mispred_o, 32'(n_mis));
`endif

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midsweep reset");
        @(negedge clk);
        model_reset();
        release_and_sweep("rst2");

        run_cycle(mk("re_pred40", 1, 32'h40, 0, 32'h0, 4'h0, 0, 0, 1, 4'h0), 1'b0);
        run_cycle(mk("fin1", 1, 32'h124, 1, 32'h08, 4'h3, 1, 1, 0, 4'h0), 1'b1);
        run_cycle(mk("fin2", 1, 32'h230, 0, 32'h0,  4'h0, 0, 0, 0, 4'h0), 1'b1);
        run_cycle(mk("fin3", 1, 32'h0c8, 1, 32'h1c, 4'h9, 0, 1, 0, 4'h0), 1'b1);
        run_cycle(mk("fin4", 1, 32'h3fc, 0, 32'h0,  4'h0, 0, 0, 0, 4'h0), 1'b1);
`ifdef GSHARE_STATS_EN
        check("stat_pred final",    stat_pred_o,    32'd5);
        check("stat_mispred final", stat_mispred_o, 32'd2);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
